// File: rtl/pcie_phy_pkg.sv
// Shared PHY constants and the per-byte Gen1/Gen2 scrambler step.
// scramble_byte is chained once per byte position in the lane datapath.
package pcie_phy_pkg;

    localparam logic [7:0]  COM_K         = 8'hBC;
    localparam logic [7:0]  SKP_K         = 8'h1C;
    localparam logic [15:0] SCRAMBLE_SEED = 16'hFFFF;

    typedef enum logic [0:0] {
        REG_BYPASS,
        REG_SKID_BUFFER
    } reg_type_e;

    // Returns {data_out, lfsr_out}. K symbols are never XORed. COM reseeds,
    // SKP leaves the LFSR untouched, and every other symbol advances it 8 steps.
    function automatic logic [23:0] scramble_byte(
        input logic [15:0] lfsr_in,
        input logic [7:0]  data,
        input logic        k
    );
        logic [15:0] lfsr;
        logic [7:0]  data_out;
        lfsr     = lfsr_in;
        data_out = data;
        if (k && data == COM_K) begin
            lfsr = SCRAMBLE_SEED;
        end else if (!(k && data == SKP_K)) begin
            for (int i = 0; i < 8; i++) begin
                if (!k) begin
                    data_out[i] = data[i] ^ lfsr[15];
                end
                // Galois step: x^16 + x^5 + x^4 + x^3 + 1
                lfsr = {lfsr[14:0], lfsr[15]} ^ {10'd0, {3{lfsr[15]}}, 3'd0};
            end
        end
        return {data_out, lfsr};
    endfunction

endpackage

// File: rtl/axis_register.sv
// AXI-Stream output register stage. The registered mode accepts a new beat
// whenever the stage is empty or is being drained in the same cycle.
module axis_register
    import pcie_phy_pkg::*;
#(
    parameter int        DATA_WIDTH  = 32,
    parameter int        KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int        USER_WIDTH  = 1,
    parameter bit        USER_ENABLE = 1'b1,
    parameter reg_type_e REG_TYPE    = REG_SKID_BUFFER
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready
);

    generate
        if (REG_TYPE == REG_BYPASS) begin : g_bypass
            assign m_axis_tdata  = s_axis_tdata;
            assign m_axis_tkeep  = s_axis_tkeep;
            assign m_axis_tvalid = s_axis_tvalid;
            assign m_axis_tlast  = s_axis_tlast;
            assign m_axis_tuser  = USER_ENABLE ? s_axis_tuser : '0;
            assign s_axis_tready = m_axis_tready;
        end else begin : g_reg
            logic                  valid_reg;
            logic [DATA_WIDTH-1:0] data_reg;
            logic [KEEP_WIDTH-1:0] keep_reg;
            logic                  last_reg;
            logic [USER_WIDTH-1:0] user_reg;

            assign s_axis_tready = !valid_reg || m_axis_tready;

            always_ff @(posedge clk) begin
                if (srst) begin
                    valid_reg <= 1'b0;
                end else if (s_axis_tready) begin
                    valid_reg <= s_axis_tvalid;
                end
            end

            always_ff @(posedge clk) begin
                if (s_axis_tvalid && s_axis_tready) begin
                    data_reg <= s_axis_tdata;
                    keep_reg <= s_axis_tkeep;
                    last_reg <= s_axis_tlast;
                    user_reg <= s_axis_tuser;
                end
            end

            assign m_axis_tdata  = data_reg;
            assign m_axis_tkeep  = keep_reg;
            assign m_axis_tvalid = valid_reg;
            assign m_axis_tlast  = last_reg;
            assign m_axis_tuser  = USER_ENABLE ? user_reg : '0;
        end
    endgenerate

endmodule

// File: rtl/pcie_gen12_scrambler.sv
// Multi-lane Gen1/Gen2 scrambler: per-lane LFSR chained across the 4 bytes of
// a beat, ordered-set bypass decided at start of packet, registered AXIS output.
module pcie_gen12_scrambler
    import pcie_phy_pkg::*;
#(
    parameter int MAX_NUM_LANES = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int USER_WIDTH    = 4,
    parameter bit SHARED_K      = 1'b1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                scramble_disable_i,
    input  logic [DATA_WIDTH*MAX_NUM_LANES-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH*MAX_NUM_LANES-1:0] s_axis_tkeep,
    input  logic                                s_axis_tvalid,
    input  logic                                s_axis_tlast,
    input  logic [USER_WIDTH*MAX_NUM_LANES-1:0] s_axis_tuser,
    output logic                                s_axis_tready,
    output logic [DATA_WIDTH*MAX_NUM_LANES-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH*MAX_NUM_LANES-1:0] m_axis_tkeep,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    output logic [USER_WIDTH*MAX_NUM_LANES-1:0] m_axis_tuser,
    input  logic                                m_axis_tready
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic                                accept;
    logic                                in_os_reg;
    logic                                sop_reg;
    logic                                in_os_eff;
    logic                                bypass;
    logic                                unused_tuser;
    logic [USER_WIDTH*MAX_NUM_LANES-1:0] k_flags;
    logic [DATA_WIDTH*MAX_NUM_LANES-1:0] scr_data;

    assign accept       = s_axis_tvalid && s_axis_tready;
    // Only a packet opening with COM on lane 0 is treated as an ordered set.
    assign in_os_eff    = sop_reg ? (k_flags[0] && s_axis_tdata[7:0] == COM_K) : in_os_reg;
    assign bypass       = in_os_eff || scramble_disable_i;
    assign unused_tuser = ^s_axis_tuser;

    generate
        for (genvar gi = 0; gi < MAX_NUM_LANES; gi++) begin : g_lane
            logic [15:0]           lfsr_reg;
            logic [15:0]           lfsr_next;
            logic [23:0]           res;
            logic [DATA_WIDTH-1:0] lane_data;

            if (SHARED_K) begin : g_shared_k
                assign k_flags[USER_WIDTH*gi +: USER_WIDTH] = s_axis_tuser[USER_WIDTH-1:0];
            end else begin : g_lane_k
                assign k_flags[USER_WIDTH*gi +: USER_WIDTH] = s_axis_tuser[USER_WIDTH*gi +: USER_WIDTH];
            end

            always_comb begin
                lfsr_next = lfsr_reg;
                res       = '0;
                lane_data = '0;
                for (int b = 0; b < BYTES; b++) begin
                    res = scramble_byte(lfsr_next, s_axis_tdata[DATA_WIDTH*gi + 8*b +: 8],
                                        k_flags[USER_WIDTH*gi + b]);
                    lane_data[8*b +: 8] = bypass ? s_axis_tdata[DATA_WIDTH*gi + 8*b +: 8]
                                                 : res[23:16];
                    lfsr_next = res[15:0];
                end
            end

            assign scr_data[DATA_WIDTH*gi +: DATA_WIDTH] = lane_data;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    lfsr_reg <= SCRAMBLE_SEED;
                end else if (accept) begin
                    lfsr_reg <= lfsr_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_os_reg <= 1'b0;
            sop_reg   <= 1'b1;
        end else if (accept) begin
            in_os_reg <= s_axis_tlast ? 1'b0 : in_os_eff;
            sop_reg   <= s_axis_tlast;
        end
    end

    axis_register #(
        .DATA_WIDTH  (DATA_WIDTH * MAX_NUM_LANES),
        .KEEP_WIDTH  (KEEP_WIDTH * MAX_NUM_LANES),
        .USER_WIDTH  (USER_WIDTH * MAX_NUM_LANES),
        .USER_ENABLE (1'b1),
        .REG_TYPE    (REG_SKID_BUFFER)
    ) u_out_reg (
        .clk           (clk_i),
        .srst          (rst_i),
        .s_axis_tdata  (scr_data),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (k_flags),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_pcie_gen12_scrambler.sv
// Testbench for pcie_gen12_scrambler: reference model tracks each lane's
// position in a precomputed keystream rather than an LFSR register.
module tb_pcie_gen12_scrambler;

    localparam int NL      = 4;
    localparam int KS_LEN  = 8192;
    localparam int MAX_CYC = 2000;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         scramble_disable_i = 1'b0;
    logic [127:0] s_axis_tdata = '0;
    logic [15:0]  s_axis_tkeep = '1;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic [15:0]  s_axis_tuser = '0;
    logic         s_axis_tready;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic [15:0]  m_axis_tuser;
    logic         m_axis_tready = 1'b1;

    always #5 clk_i = ~clk_i;

    pcie_gen12_scrambler dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .scramble_disable_i (scramble_disable_i),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tuser       (s_axis_tuser),
        .s_axis_tready      (s_axis_tready),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tkeep       (m_axis_tkeep),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tuser       (m_axis_tuser),
        .m_axis_tready      (m_axis_tready)
    );

    typedef struct {
        logic [127:0] data;
        logic [15:0]  user;
        logic [15:0]  keep;
        logic         last;
        logic         dis;
    } beat_t;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  user;
        logic [15:0]  keep;
        logic         last;
    } obs_t;

    beat_t      in_q[$];
    obs_t       exp_q[$];
    obs_t       out_q[$];
    logic [7:0] ks [KS_LEN];
    int         pos [NL];
    bit         m_in_os;
    bit         m_sop;
    int         checks = 0;
    int         passed = 0;

    // ks[n] is the scramble byte applied after n byte advances from the seed.
    function automatic void build_keystream();
        logic [15:0] s = 16'hFFFF;
        for (int n = 0; n < KS_LEN; n++) begin
            for (int i = 0; i < 8; i++) begin
                ks[n][i] = s[15];
                s = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
            end
        end
    endfunction

    function automatic void model_reset();
        for (int l = 0; l < NL; l++) pos[l] = 0;
        m_in_os = 1'b0;
        m_sop   = 1'b1;
    endfunction

    function automatic obs_t model_beat(beat_t b);
        obs_t       o;
        bit         os;
        logic [3:0] k;
        logic [7:0] v;
        k      = b.user[3:0];
        os     = m_sop ? (k[0] && b.data[7:0] == 8'hBC) : m_in_os;
        o.data = b.data;
        o.user = {4{k}};
        o.keep = b.keep;
        o.last = b.last;
        for (int l = 0; l < NL; l++) begin
            for (int y = 0; y < 4; y++) begin
                v = b.data[32*l + 8*y +: 8];
                if (k[y] && v == 8'hBC) begin
                    pos[l] = 0;
                end else if (!(k[y] && v == 8'h1C)) begin
                    if (!k[y] && !os && !b.dis)
                        o.data[32*l + 8*y +: 8] = v ^ ks[pos[l] % KS_LEN];
                    pos[l]++;
                end
            end
        end
        m_in_os = b.last ? 1'b0 : os;
        m_sop   = b.last;
        return o;
    endfunction

    task automatic clear_queues();
        in_q.delete();
        exp_q.delete();
        out_q.delete();
    endtask

    task automatic add_beat(input logic [127:0] data, input logic [3:0] k,
                            input logic last, input logic dis);
        beat_t       b;
        logic [11:0] junk;
        junk   = 12'($urandom);
        b.data = data;
        b.user = {junk, k};
        b.keep = 16'hFFFF;
        b.last = last;
        b.dis  = dis;
        in_q.push_back(b);
        exp_q.push_back(model_beat(b));
    endtask

    // Drives in_q and collects every output handshake into out_q.
    task automatic run_beats(input bit rand_stall);
        int   sent = 0;
        int   cyc  = 0;
        obs_t o;
        out_q.delete();
        while ((sent < in_q.size() || out_q.size() < in_q.size()) && cyc < MAX_CYC) begin
            if (sent < in_q.size() && (!rand_stall || $urandom_range(0, 3) != 0)) begin
                s_axis_tvalid      = 1'b1;
                s_axis_tdata       = in_q[sent].data;
                s_axis_tuser       = in_q[sent].user;
                s_axis_tkeep       = in_q[sent].keep;
                s_axis_tlast       = in_q[sent].last;
                scramble_disable_i = in_q[sent].dis;
            end else begin
                s_axis_tvalid      = 1'b0;
                s_axis_tdata       = {$urandom, $urandom, $urandom, $urandom};
                s_axis_tuser       = 16'($urandom);
                s_axis_tlast       = 1'($urandom);
                scramble_disable_i = 1'($urandom);
            end
            m_axis_tready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk_i);
            if (m_axis_tvalid && m_axis_tready) begin
                o.data = m_axis_tdata;
                o.user = m_axis_tuser;
                o.keep = m_axis_tkeep;
                o.last = m_axis_tlast;
                out_q.push_back(o);
            end
            if (s_axis_tvalid && s_axis_tready) sent++;
            @(posedge clk_i);
            #1;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_i);
        checks++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid);
        else passed++;
        checks++;
        if (s_axis_tready !== 1'b1) $display("FAIL reset_tready got %b want 1", s_axis_tready);
        else passed++;
        @(posedge clk_i);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_first_beat();
        clear_queues();
        add_beat('0, 4'h0, 1'b1, 1'b0);
        run_beats(1'b0);
        checks++;
        if (out_q.size() != 1) $display("FAIL first_count got %0d want 1", out_q.size());
        else passed++;
        for (int i = 0; i < out_q.size() && i < 1; i++) begin
            for (int l = 0; l < NL; l++) begin
                checks++;
                if (out_q[i].data[32*l +: 32] !== 32'h14C017FF)
                    $display("FAIL first_data lane%0d got %h want 14c017ff", l, out_q[i].data[32*l +: 32]);
                else passed++;
            end
            checks++;
            if ({out_q[i].user, out_q[i].keep, out_q[i].last} !== {exp_q[i].user, exp_q[i].keep, exp_q[i].last})
                $display("FAIL first_meta got %h/%h/%b want %h/%h/%b", out_q[i].user, out_q[i].keep,
                         out_q[i].last, exp_q[i].user, exp_q[i].keep, exp_q[i].last);
            else passed++;
        end
        $display("test_first_beat done");
    endtask

    task automatic test_skp();
        clear_queues();
        add_beat({4{32'h1C1C1CBC}}, 4'hF, 1'b1, 1'b0);
        add_beat('0, 4'h0, 1'b1, 1'b0);
        run_beats(1'b0);
        checks++;
        if (out_q.size() != 2) $display("FAIL skp_count got %0d want 2", out_q.size());
        else passed++;
        if (out_q.size() == 2) begin
            checks++;
            if (out_q[0].data !== {4{32'h1C1C1CBC}})
                $display("FAIL skp_os got %h want %h", out_q[0].data, {4{32'h1C1C1CBC}});
            else passed++;
            for (int l = 0; l < NL; l++) begin
                checks++;
                if (out_q[1].data[32*l +: 32] !== 32'h14C017FF)
                    $display("FAIL skp_idle lane%0d got %h want 14c017ff", l, out_q[1].data[32*l +: 32]);
                else passed++;
            end
        end
        $display("test_skp done");
    endtask

    task automatic test_ts1();
        clear_queues();
        add_beat({4{32'h4A4A4ABC}}, 4'h1, 1'b0, 1'b0);
        add_beat({4{32'h4A4A4A4A}}, 4'h0, 1'b0, 1'b0);
        add_beat({4{32'h4A4A4A4A}}, 4'h0, 1'b0, 1'b0);
        add_beat({4{32'h4A4A4A4A}}, 4'h0, 1'b1, 1'b0);
        add_beat('0, 4'h0, 1'b1, 1'b0);
        run_beats(1'b0);
        checks++;
        if (out_q.size() != 5) $display("FAIL ts1_count got %0d want 5", out_q.size());
        else passed++;
        for (int i = 0; i < out_q.size() && i < 4; i++) begin
            checks++;
            if (out_q[i].data !== in_q[i].data || out_q[i].last !== in_q[i].last)
                $display("FAIL ts1_body beat%0d got %h want %h", i, out_q[i].data, in_q[i].data);
            else passed++;
        end
        if (out_q.size() == 5) begin
            for (int l = 0; l < NL; l++) begin
                checks++;
                if (out_q[4].data[32*l +: 32] !== {ks[18], ks[17], ks[16], ks[15]})
                    $display("FAIL ts1_idle lane%0d got %h want %h", l, out_q[4].data[32*l +: 32],
                             {ks[18], ks[17], ks[16], ks[15]});
                else passed++;
            end
        end
        $display("test_ts1 done");
    endtask

    task automatic test_two_idle();
        clear_queues();
        add_beat({4{32'h1C1C1CBC}}, 4'hF, 1'b1, 1'b0);
        add_beat('0, 4'h0, 1'b0, 1'b0);
        add_beat('0, 4'h0, 1'b1, 1'b0);
        run_beats(1'b0);
        checks++;
        if (out_q.size() != 3) $display("FAIL two_idle_count got %0d want 3", out_q.size());
        else passed++;
        if (out_q.size() == 3) begin
            for (int l = 0; l < NL; l++) begin
                checks++;
                if (out_q[1].data[32*l +: 32] !== 32'h14C017FF)
                    $display("FAIL two_idle_b0 lane%0d got %h want 14c017ff", l, out_q[1].data[32*l +: 32]);
                else passed++;
                checks++;
                if (out_q[2].data[32*l +: 32] !== 32'h8202E7B2)
                    $display("FAIL two_idle_b1 lane%0d got %h want 8202e7b2", l, out_q[2].data[32*l +: 32]);
                else passed++;
            end
        end
        $display("test_two_idle done");
    endtask

    task automatic test_back_to_back();
        clear_queues();
        add_beat({4{32'h1C1C1CBC}}, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) add_beat('0, 4'h0, 1'(i == 15), 1'b0);
        run_beats(1'b1);
        checks++;
        if (out_q.size() != exp_q.size())
            $display("FAIL b2b_count got %0d want %0d", out_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last)
                $display("FAIL b2b_beat%0d got %h want %h", i, out_q[i].data, exp_q[i].data);
            else passed++;
        end
        @(negedge clk_i);
        checks++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL b2b_drained got %b want 0", m_axis_tvalid);
        else passed++;
        @(posedge clk_i);
        #1;
        $display("test_back_to_back done");
    endtask

    task automatic test_disable();
        clear_queues();
        add_beat({4{32'h1C1C1CBC}}, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) add_beat('0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) add_beat('0, 4'h0, 1'(i == 2), 1'b0);
        run_beats(1'b0);
        checks++;
        if (out_q.size() != 7) $display("FAIL dis_count got %0d want 7", out_q.size());
        else passed++;
        if (out_q.size() == 7) begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (out_q[i].data !== 128'd0) $display("FAIL dis_bypass beat%0d got %h want 0", i, out_q[i].data);
                else passed++;
            end
            checks++;
            if (out_q[4].data[31:0] !== {ks[15], ks[14], ks[13], ks[12]})
                $display("FAIL dis_resume got %h want %h", out_q[4].data[31:0], {ks[15], ks[14], ks[13], ks[12]});
            else passed++;
            for (int i = 4; i < 7; i++) begin
                checks++;
                if (out_q[i].data !== exp_q[i].data)
                    $display("FAIL dis_scr beat%0d got %h want %h", i, out_q[i].data, exp_q[i].data);
                else passed++;
            end
        end
        $display("test_disable done");
    endtask

    task automatic test_random();
        logic [127:0] d;
        logic [3:0]   k;
        int           r;
        clear_queues();
        for (int i = 0; i < 48; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            k = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            for (int l = 0; l < NL; l++) begin
                for (int y = 0; y < 4; y++) begin
                    r = $urandom_range(0, 3);
                    if (k[y] && r == 0) d[32*l + 8*y +: 8] = 8'hBC;
                    if (k[y] && r == 1) d[32*l + 8*y +: 8] = 8'h1C;
                end
            end
            add_beat(d, k, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
        end
        run_beats(1'b1);
        checks++;
        if (out_q.size() != exp_q.size())
            $display("FAIL rand_count got %0d want %0d", out_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (out_q[i].data !== exp_q[i].data)
                $display("FAIL rand_data beat%0d got %h want %h", i, out_q[i].data, exp_q[i].data);
            else passed++;
            checks++;
            if ({out_q[i].user, out_q[i].keep, out_q[i].last} !== {exp_q[i].user, exp_q[i].keep, exp_q[i].last})
                $display("FAIL rand_meta beat%0d got %h/%h/%b want %h/%h/%b", i, out_q[i].user, out_q[i].keep,
                         out_q[i].last, exp_q[i].user, exp_q[i].keep, exp_q[i].last);
            else passed++;
        end
        $display("test_random done");
    endtask

    task automatic test_reset_mid();
        clear_queues();
        s_axis_tvalid      = 1'b1;
        s_axis_tdata       = {4{32'h12345678}};
        s_axis_tuser       = '0;
        s_axis_tlast       = 1'b0;
        scramble_disable_i = 1'b0;
        m_axis_tready      = 1'b0;
        @(posedge clk_i);
        #1;
        s_axis_tvalid = 1'b0;
        @(negedge clk_i);
        checks++;
        if (m_axis_tvalid !== 1'b1) $display("FAIL mid_held got %b want 1", m_axis_tvalid);
        else passed++;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_axis_tready = 1'b1;
        model_reset();
        @(negedge clk_i);
        checks++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL mid_dropped got %b want 0", m_axis_tvalid);
        else passed++;
        @(posedge clk_i);
        #1;
        add_beat('0, 4'h0, 1'b1, 1'b0);
        run_beats(1'b0);
        checks++;
        if (out_q.size() != 1) $display("FAIL mid_count got %0d want 1", out_q.size());
        else passed++;
        for (int i = 0; i < out_q.size() && i < 1; i++) begin
            checks++;
            if (out_q[i].data !== {4{32'h14C017FF}})
                $display("FAIL mid_reseed got %h want %h", out_q[i].data, {4{32'h14C017FF}});
            else passed++;
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        build_keystream();
        model_reset();
        test_reset();
        test_first_beat();
        test_skp();
        test_ts1();
        test_two_idle();
        test_back_to_back();
        test_disable();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pcie_gen12_scrambler.md
Name: pcie_gen12_scrambler

Overview:
Per-lane Gen1/Gen2 (8b/10b) scrambler directly downstream of the ordered-set generator. It consumes the multi-lane AXI-Stream of 32-bit-per-lane symbols with per-byte K flags and applies the x^16+x^5+x^4+x^3+1 LFSR to data symbols. It honours the COM reset, SKP hold and ordered-set bypass rules, then forwards the stream to the 8b/10b encoder/PIPE stage through a registered AXIS output.

Parameters:
MAX_NUM_LANES, 4, number of lanes carried in parallel
DATA_WIDTH, 32, bits per lane per beat (4 symbols; fixed at 32)
KEEP_WIDTH, DATA_WIDTH/8, keep bits per lane
USER_WIDTH, 4, K-flag bits per lane (bit b = byte b is a K symbol)
SHARED_K, 1, 1: K flags for all lanes taken from s_axis_tuser[3:0]; 0: per-lane flags at tuser[USER_WIDTH*l+:4]

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
scramble_disable_i  in  1  1 = bypass XOR (LFSR still tracks); sampled per accepted beat
s_axis_tdata  in  DATA_WIDTH*MAX_NUM_LANES  lane l at [32*l+:32], byte 0 first on wire
s_axis_tkeep  in  KEEP_WIDTH*MAX_NUM_LANES  passed through
s_axis_tvalid  in  1  input beat valid
s_axis_tlast  in  1  last beat of packet (ordered set or data block)
s_axis_tuser  in  USER_WIDTH*MAX_NUM_LANES  K flags
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_WIDTH*MAX_NUM_LANES  scrambled symbols
m_axis_tkeep  out  KEEP_WIDTH*MAX_NUM_LANES  = input keep
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  = input last
m_axis_tuser  out  USER_WIDTH*MAX_NUM_LANES  K flags, expanded per lane when SHARED_K=1
m_axis_tready  in  1  downstream ready

Behaviour:
- Reset: m_axis_tvalid=0, all lane LFSRs=16'hFFFF, in_os=0, sop=1.
- Latency: exactly 1 cycle from accepted input beat to m_axis_tvalid when m_axis_tready=1. Full throughput, one beat/cycle.
- Handshake: s_axis_tready follows skid-buffer rules (high when output empty or m_axis_tready). An accepted beat is s_axis_tvalid&&s_axis_tready. LFSR, in_os and sop update only on accepted beats; a stall freezes all state.
- Bytes are processed in order 0..3 within each lane, and LFSR updates chain across the 4 bytes within one cycle (unrolled).
- Per byte, with K flag k and value v:
  - k && v==8'hBC (COM): output unchanged; LFSR := FFFF for the next byte, no advance.
  - k && v==8'h1C (SKP): output unchanged; LFSR unchanged.
  - Other K: output unchanged; LFSR advances 8 steps.
  - Data byte: LFSR advances 8 steps. Output = v XOR scramble byte, unless in_os_eff=1 or scramble_disable_i=1, in which case output = v.
- LFSR step (Galois), per bit i=0..7 (LSB first):
  - out[i] = v[i]^lfsr[15]
  - new[0] = lfsr[15]; new[3] = lfsr[2]^lfsr[15]; new[4] = lfsr[3]^lfsr[15]; new[5] = lfsr[4]^lfsr[15]; new[k] = lfsr[k-1] otherwise.
- Ordered-set detection:
  - On a start-of-packet beat (sop=1), in_os_eff = (lane0 byte0 is K and ==BC). Otherwise in_os_eff = in_os.
  - in_os := in_os_eff after each accepted beat. sop := s_axis_tlast.
  - After a tlast beat, in_os is cleared for the next packet.
  - Result: TS1/TS2/EIOS/SKP bodies pass unscrambled; logical-idle data packets without COM are scrambled.
- COM mid-packet on a non-sop beat still resets the LFSR but does not change in_os.
- Lanes are independent: each lane applies its own K flags and LFSR. With SHARED_K=1 all lane LFSRs remain identical.
- tkeep is not used to skip bytes: all 4 bytes are always processed. Upstream guarantees tkeep='1.
- Reset mid-packet: output beat dropped, LFSR=FFFF, sop=1.

Decomposition:
- pcie_phy_pkg gains: COM_K=8'hBC, SKP_K=8'h1C, SCRAMBLE_SEED=16'hFFFF, and the function scramble_byte(lfsr_in, data, k) returning {data_out, lfsr_out}.
- Output stage reuses axis_register with REG_TYPE SkidBuffer and USER_ENABLE=1.
- No other sub-module.

Test Plan:
- Reset -> m_axis_tvalid=0. First beat afterwards with all-data 32'h0 (no prior COM, seed FFFF) -> lane tdata=32'h14C017FF on every lane.
- SKP OS beat {BC,1C,1C,1C}, K=4'hF, tlast -> output identical. Next data packet of 32'h0 -> 32'h14C017FF (SKP did not advance LFSR).
- TS1 packet of 4 beats, byte0 COM, data bytes 0x4A -> all data bytes output unchanged. Following idle 32'h0 beat -> bytes follow the LFSR after 15 advances from FFFF, matching the model.
- Two consecutive idle beats 32'h0 after COM -> beat0=32'h14C017FF, beat1=32'h8202E7B2.
- m_axis_tready toggled 0/1 randomly across a 16-beat idle stream -> output sequence equals the no-stall sequence, with no drops or duplicates.
- scramble_disable_i=1 over idle 32'h0 -> output 0. After deasserting mid-stream, scrambled bytes resume at the correct LFSR position.
